multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer_if.sv | 31 +++
 rtl/multdiv_sequencer.sv | 103 ++++++++++
 tb/tb_multdiv_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// Control/status bundle between the multiply/divide sequencer and its datapath.
// The master side issues operation pulses and datapath flags; the slave side is the sequencer.
interface multdiv_sequencer_if;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic       divisor_zero;
   logic       mult_ovf;
   logic       load;
   logic       mult_step;
   logic       div_step;
   logic       busy;
   logic [5:0] iter_count;
   logic       data_resultRDY;
   logic       data_exception;
   logic [1:0] state_dbg;

   // ctrl_MULT/ctrl_DIV are single-cycle start pulses with no ready: a pulse
   // is always accepted and restarts the sequencer; data_resultRDY is a
   // one-cycle strobe that qualifies data_exception.
   modport master (
      output ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
      input  load, mult_step, div_step, busy, iter_count,
             data_resultRDY, data_exception, state_dbg
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
      output load, mult_step, div_step, busy, iter_count,
             data_resultRDY, data_exception, state_dbg
   );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iteration sequencer for a shared multiply/divide datapath: LOAD, a fixed
// number of step cycles, then a one-cycle DONE strobe with an exception flag.
module multdiv_sequencer #(
   parameter int MULT_ITERS = 16,
   parameter int DIV_ITERS  = 32
) (
   input logic               clk,
   input logic               clr,
   multdiv_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [5:0] MULT_N = 6'(MULT_ITERS);
   localparam logic [5:0] DIV_N  = 6'(DIV_ITERS);

   state_t     state, state_n;
   logic       op, op_n;
   logic [5:0] iter, iter_n;
   logic       dz, dz_n;

   logic load, mult_step, div_step, busy, result_rdy, exception;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         op    <= 1'b0;
         iter  <= 6'd0;
         dz    <= 1'b0;
      end else begin
         state <= state_n;
         op    <= op_n;
         iter  <= iter_n;
         dz    <= dz_n;
      end
   end

   always_comb begin
      state_n    = state;
      op_n       = op;
      iter_n     = iter;
      dz_n       = dz;
      load       = 1'b0;
      mult_step  = 1'b0;
      div_step   = 1'b0;
      busy       = 1'b0;
      result_rdy = 1'b0;
      exception  = 1'b0;

      case (state)
         IDLE: begin
         end
         LOAD: begin
            load = 1'b1;
            busy = 1'b1;
            if (op && bus.divisor_zero) begin
               state_n = DONE;
               dz_n    = 1'b1;
               iter_n  = 6'd0;
            end else begin
               state_n = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            mult_step = ~op;
            div_step  = op;
            // <= 1 rather than == 1 so a zero iteration count cannot wrap
            if (iter <= 6'd1) begin
               state_n = DONE;
               iter_n  = 6'd0;
            end else begin
               iter_n = iter - 6'd1;
            end
         end
         DONE: begin
            busy       = 1'b1;
            result_rdy = 1'b1;
            exception  = op ? dz : bus.mult_ovf;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A start pulse overrides whatever is in flight; multiply has priority.
      if (bus.ctrl_MULT || bus.ctrl_DIV) begin
         state_n = LOAD;
         op_n    = ~bus.ctrl_MULT;
         iter_n  = bus.ctrl_MULT ? MULT_N : DIV_N;
         dz_n    = 1'b0;
      end
   end

   assign bus.load           = load;
   assign bus.mult_step      = mult_step;
   assign bus.div_step       = div_step;
   assign bus.busy           = busy;
   assign bus.iter_count     = iter;
   assign bus.data_resultRDY = result_rdy;
   assign bus.data_exception = exception;
   assign bus.state_dbg      = state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized checks of multdiv_sequencer against a cycle-indexed
// model of the expected output trace of each operation.
module tb_multdiv_sequencer;

   localparam int MULT_ITERS = 16;
   localparam int DIV_ITERS  = 32;

   logic clk;
   logic clr;
   int   total_cnt;
   int   pass_cnt;
   int   fail_cnt;

   multdiv_sequencer_if bus ();

   multdiv_sequencer #(.MULT_ITERS(MULT_ITERS), .DIV_ITERS(DIV_ITERS)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {load, mult_step, div_step, busy, resultRDY, exception, iter_count}
   // in cycle k after the edge that sampled the start pulse.
   function automatic logic [11:0] model(bit is_div, bit dz, bit ovf, int k);
      int   n;
      int   it;
      logic l, ms, ds, b, r, e;
      n  = is_div ? DIV_ITERS : MULT_ITERS;
      it = 0;
      l = 0; ms = 0; ds = 0; b = 0; r = 0; e = 0;
      if (k == 1) begin
         l = 1; b = 1; it = n;
      end else if (is_div && dz) begin
         if (k == 2) begin
            b = 1; r = 1; e = 1;
         end
      end else if (k <= n + 1) begin
         b = 1; ms = !is_div; ds = is_div; it = n - (k - 2);
      end else if (k == n + 2) begin
         b = 1; r = 1; e = is_div ? 1'b0 : ovf;
      end
      return {l, ms, ds, b, r, e, 6'(it)};
   endfunction

   function automatic logic [11:0] observed();
      return {bus.load, bus.mult_step, bus.div_step, bus.busy,
              bus.data_resultRDY, bus.data_exception, bus.iter_count};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a start pulse now (called away from the rising edge), then check
   // ncyc cycles of output against the model.
   task automatic run_seq(input bit m, input bit d, input bit dz, input bit ovf,
                          input int ncyc, input string tag,
                          output int rdy_cnt, output int step_cnt);
      bit         is_div;
      logic [11:0] o;
      is_div   = !m && d;
      rdy_cnt  = 0;
      step_cnt = 0;
      bus.divisor_zero = dz;
      bus.mult_ovf     = ovf;
      bus.ctrl_MULT    = m;
      bus.ctrl_DIV     = d;
      @(posedge clk);
      #1;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         o = observed();
         check($sformatf("%s_c%0d", tag, k), 32'(o), 32'(model(is_div, dz, ovf, k)));
         rdy_cnt  += int'(o[7]);
         step_cnt += int'(o[10]) + int'(o[9]);
      end
   endtask

   initial begin
      int r1, s1, r2, s2, sel, len;
      bit m, d, dz, ovf;
      total_cnt = 0;
      pass_cnt  = 0;
      fail_cnt  = 0;
      bus.ctrl_MULT    = 1'b0;
      bus.ctrl_DIV     = 1'b0;
      bus.divisor_zero = 1'b0;
      bus.mult_ovf     = 1'b0;
      clr = 1'b1;

      repeat (2) @(negedge clk);
      check("reset_held", 32'(observed()), 32'd0);
      bus.ctrl_MULT = 1'b1;
      @(negedge clk);
      check("reset_ignores_ctrl", 32'(observed()), 32'd0);
      bus.ctrl_MULT = 1'b0;
      clr = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 32'(observed()), 32'd0);

      run_seq(1, 0, 0, 0, MULT_ITERS + 4, "mult", r1, s1);
      check("mult_steps", 32'(s1), 32'(MULT_ITERS));
      check("mult_rdy_count", 32'(r1), 32'd1);

      run_seq(0, 1, 0, 0, DIV_ITERS + 4, "div", r1, s1);
      check("div_steps", 32'(s1), 32'(DIV_ITERS));
      check("div_rdy_count", 32'(r1), 32'd1);

      run_seq(0, 1, 1, 0, 4, "div0", r1, s1);
      check("div0_steps", 32'(s1), 32'd0);
      check("div0_rdy_count", 32'(r1), 32'd1);

      run_seq(1, 1, 0, 1, MULT_ITERS + 4, "both_ovf", r1, s1);
      check("both_steps", 32'(s1), 32'(MULT_ITERS));

      run_seq(1, 0, 0, 0, 4, "abort_m", r1, s1);
      run_seq(0, 1, 0, 0, DIV_ITERS + 4, "abort_d", r2, s2);
      check("abort_rdy_total", 32'(r1 + r2), 32'd1);
      check("abort_div_steps", 32'(s2), 32'(DIV_ITERS));

      run_seq(0, 1, 0, 0, 10, "clr_div", r1, s1);
      #2 clr = 1'b1;
      #1 check("clr_async_outputs", 32'(observed()), 32'd0);
      #1 clr = 1'b0;
      r2 = 0;
      for (int k = 1; k <= DIV_ITERS + 4; k++) begin
         @(negedge clk);
         check($sformatf("clr_quiet_c%0d", k), 32'(observed()), 32'd0);
         r2 += int'(bus.data_resultRDY);
      end
      check("clr_no_rdy", 32'(r2), 32'd0);
      run_seq(1, 0, 0, 0, MULT_ITERS + 3, "post_clr", r1, s1);

      for (int t = 0; t < 10; t++) begin
         sel = $urandom_range(1, 3);
         m   = sel[0];
         d   = sel[1];
         dz  = 1'($urandom_range(0, 1));
         ovf = 1'($urandom_range(0, 1));
         len = (!m && d) ? (dz ? 3 : DIV_ITERS + 3) : MULT_ITERS + 3;
         // Occasionally cut the operation short so the next pulse aborts it.
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 6);
         run_seq(m, d, dz, ovf, len, $sformatf("rnd%0d", t), r1, s1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Let any operation left by the random loop finish before the summary.
      repeat (DIV_ITERS + 4) @(negedge clk);
      check("final_idle", 32'(observed()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
